// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - RV32I funct3 size/sign encodings
//   - rsp_fault codes
//   - FSM state type
//   - helpers for region legality and access size
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FLT_NONE       = 2'b00;
  localparam logic [1:0] FLT_MISALIGNED = 2'b01;
  localparam logic [1:0] FLT_ACCESS     = 2'b10;
  localparam logic [1:0] FLT_ILLEGAL    = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Stores may only touch RAM; loads may touch RAM or ROM.
  function automatic logic region_ok(input logic [15:0] region,
                                     input logic        is_store,
                                     input logic [15:0] ram,
                                     input logic [15:0] rom);
    return is_store ? (region == ram) : ((region == ram) || (region == rom));
  endfunction

  // Number of bytes touched by an access of the given funct3.
  function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_W:        return 3'd4;
      F3_H, F3_HU: return 3'd2;
      default:     return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: selects the addressed bytes out of the two-word
// window {word1, word0} starting at byte offset off, then sign- or
// zero-extends according to funct3.
//   word0     in  32  first (lower-addressed) word
//   word1_lo  in  24  low three bytes of the following word (never more is needed)
//   off       in   2  byte offset of the access inside word0
//   funct3    in   3  RV32I load size/sign
//   load_data out 32  extended result (0 for unsupported funct3)
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word0,
  input  logic [23:0] word1_lo,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [55:0] window;
  logic [31:0] sel;

  always_comb begin
    window = {word1_lo, word0};
    case (off)
      2'd0:    sel = window[31:0];
      2'd1:    sel = window[39:8];
      2'd2:    sel = window[47:16];
      default: sel = window[55:24];
    endcase

    case (funct3)
      F3_B:    load_data = {{24{sel[7]}}, sel[7:0]};
      F3_H:    load_data = {{16{sel[15]}}, sel[15:0]};
      F3_W:    load_data = sel;
      F3_BU:   load_data = {24'd0, sel[7:0]};
      F3_HU:   load_data = {16'd0, sel[15:0]};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the data-memory interface. Accepts one
// request at a time, issues up to two word accesses, returns an extended load
// result or a fault code.
// Configuration macro: LSU_MISALIGNED_SPLIT_EN -- when defined, accesses that
// cross a word boundary are split into two word accesses (ACC0 + ACC1);
// otherwise unaligned H/W accesses fault as misaligned and ACC1 is unused.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   req_valid/req_ready          request handshake
//   req_is_store, req_funct3     operation, size/sign
//   req_address, req_store_data  byte address, right-justified store value
//   dmem_write_enable/address/write_data/write_mask  data memory drive
//   dmem_read_data               combinational read word
//   rsp_valid/rsp_ready          response handshake
//   rsp_load_data, rsp_fault     result and fault code
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [15:0] RAM_REGION = 16'h1000,
  parameter logic [15:0] ROM_REGION = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_store_data,
  output logic        dmem_write_enable,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_write_data,
  output logic [3:0]  dmem_write_mask,
  input  logic [31:0] dmem_read_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_load_data,
  output logic [1:0]  rsp_fault
);

  lsu_state_e  state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_data_q, store_data_d;
  logic [1:0]  fault_q, fault_d;
  logic [31:0] word0_q, word0_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
  logic        split_q, split_d;
  logic [23:0] word1_q, word1_d;
  logic [15:0] word1_region;
  logic        split_in;
  logic [7:0]  mask_wide;
  logic [63:0] data_wide;
`endif

  logic [2:0]  acc_size;
  logic        illegal_in, misaligned_in, access_in;
  logic [1:0]  fault_in;
  logic [3:0]  base_mask;
  logic [31:0] word_addr;
  logic [23:0] word1_lo;
  logic [31:0] align_data;

  // Request classification, evaluated on the live request inputs in IDLE.
  always_comb begin
    acc_size = access_bytes(req_funct3);
    if (req_is_store) begin
      illegal_in = (req_funct3 != F3_B) && (req_funct3 != F3_H) && (req_funct3 != F3_W);
    end else begin
      illegal_in = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
    end
`ifdef LSU_MISALIGNED_SPLIT_EN
    misaligned_in = 1'b0;
    split_in      = ({1'b0, req_address[1:0]} + acc_size) > 3'd4;
    // Region of the next word: bump [31:16] only when the word address
    // carries out of the low half (covers the 0xFFFFFFFC -> 0 wrap too).
    word1_region  = req_address[31:16] + {15'd0, &req_address[15:2]};
    access_in     = !region_ok(req_address[31:16], req_is_store, RAM_REGION, ROM_REGION) ||
                    (split_in && !region_ok(word1_region, req_is_store, RAM_REGION, ROM_REGION));
`else
    misaligned_in = ((acc_size == 3'd2) && req_address[0]) ||
                    ((acc_size == 3'd4) && (req_address[1:0] != 2'b00));
    access_in     = !region_ok(req_address[31:16], req_is_store, RAM_REGION, ROM_REGION);
`endif
    if (illegal_in)         fault_in = FLT_ILLEGAL;
    else if (misaligned_in) fault_in = FLT_MISALIGNED;
    else if (access_in)     fault_in = FLT_ACCESS;
    else                    fault_in = FLT_NONE;
  end

  // Next-state and request capture.
  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    store_data_d = store_data_q;
    fault_d      = fault_q;
    word0_d      = word0_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
    split_d      = split_q;
    word1_d      = word1_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          is_store_d   = req_is_store;
          funct3_d     = req_funct3;
          addr_d       = req_address;
          store_data_d = req_store_data;
          fault_d      = fault_in;
          word0_d      = '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
          split_d      = split_in;
          word1_d      = '0;
`endif
          state_d      = (fault_in != FLT_NONE) ? RESP : ACC0;
        end
      end
      ACC0: begin
        if (!is_store_q) word0_d = dmem_read_data;
`ifdef LSU_MISALIGNED_SPLIT_EN
        state_d = split_q ? ACC1 : RESP;
`else
        state_d = RESP;
`endif
      end
      ACC1: begin
`ifdef LSU_MISALIGNED_SPLIT_EN
        if (!is_store_q) word1_d = dmem_read_data[23:0];
        state_d = RESP;
`else
        state_d = IDLE;
`endif
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= '0;
      addr_q       <= '0;
      store_data_q <= '0;
      fault_q      <= FLT_NONE;
      word0_q      <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_q      <= 1'b0;
      word1_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      store_data_q <= store_data_d;
      fault_q      <= fault_d;
      word0_q      <= word0_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
      split_q      <= split_d;
      word1_q      <= word1_d;
`endif
    end
  end

`ifdef LSU_MISALIGNED_SPLIT_EN
  assign word1_lo = word1_q;
`else
  assign word1_lo = '0;
`endif

  lsu_load_align u_load_align (
    .word0     (word0_q),
    .word1_lo  (word1_lo),
    .off       (addr_q[1:0]),
    .funct3    (funct3_q),
    .load_data (align_data)
  );

  // Memory and response drive; everything is zero outside its own state.
  always_comb begin
    req_ready         = (state_q == IDLE);
    dmem_write_enable = 1'b0;
    dmem_address      = '0;
    dmem_write_data   = '0;
    dmem_write_mask   = '0;
    rsp_valid         = 1'b0;
    rsp_load_data     = '0;
    rsp_fault         = FLT_NONE;

    word_addr = {addr_q[31:2], 2'b00};
    case (access_bytes(funct3_q))
      3'd4:    base_mask = 4'b1111;
      3'd2:    base_mask = 4'b0011;
      default: base_mask = 4'b0001;
    endcase
`ifdef LSU_MISALIGNED_SPLIT_EN
    // Shift into an 8-lane / 64-bit window; the upper half is the ACC1 word.
    mask_wide = {4'b0000, base_mask} << addr_q[1:0];
    data_wide = {32'd0, store_data_q} << {addr_q[1:0], 3'b000};
`endif

    case (state_q)
      ACC0: begin
        dmem_write_enable = is_store_q;
        dmem_address      = word_addr;
`ifdef LSU_MISALIGNED_SPLIT_EN
        dmem_write_mask   = mask_wide[3:0];
        dmem_write_data   = data_wide[31:0];
`else
        dmem_write_mask   = base_mask << addr_q[1:0];
        dmem_write_data   = store_data_q << {addr_q[1:0], 3'b000};
`endif
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      ACC1: begin
        dmem_write_enable = is_store_q;
        dmem_address      = word_addr + 32'd4;
        dmem_write_mask   = mask_wide[7:4];
        dmem_write_data   = data_wide[63:32];
      end
`endif
      RESP: begin
        rsp_valid     = 1'b1;
        rsp_fault     = fault_q;
        rsp_load_data = (!is_store_q && (fault_q == FLT_NONE)) ? align_data : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_store_data;
  logic        dmem_write_enable;
  logic [31:0] dmem_address;
  logic [31:0] dmem_write_data;
  logic [3:0]  dmem_write_mask;
  logic [31:0] dmem_read_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_load_data;
  logic [1:0]  rsp_fault;

  load_store_unit #(.RAM_REGION(16'h1000), .ROM_REGION(16'h0000)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_is_store      (req_is_store),
    .req_funct3        (req_funct3),
    .req_address       (req_address),
    .req_store_data    (req_store_data),
    .dmem_write_enable (dmem_write_enable),
    .dmem_address      (dmem_address),
    .dmem_write_data   (dmem_write_data),
    .dmem_write_mask   (dmem_write_mask),
    .dmem_read_data    (dmem_read_data),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_load_data     (rsp_load_data),
    .rsp_fault         (rsp_fault)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // ---------------- data memory environment (RAM 0x1000xxxx, ROM 0x0000xxxx)
  logic [31:0] dmem [0:63];
  logic        mem_inited = 1'b0;
  int          rd_idx;

  function automatic int widx(input logic [31:0] a);
    if (a[31:16] == 16'h1000) return int'(a[6:2]);
    if (a[31:16] == 16'h0000) return 32 + int'(a[6:2]);
    return -1;
  endfunction

  always_comb begin
    rd_idx = widx(dmem_address);
    dmem_read_data = (rd_idx >= 0) ? dmem[rd_idx] : 32'hBAD0BAD0;
  end

  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 64; i++) dmem[i] <= $urandom;
      mem_inited <= 1'b1;
    end else if (dmem_write_enable && dmem_address[31:16] == 16'h1000) begin
      for (int l = 0; l < 4; l++)
        if (dmem_write_mask[l]) dmem[widx(dmem_address)][l*8 +: 8] <= dmem_write_data[l*8 +: 8];
    end
  end

  // ---------------- reference model: byte-addressed memory + transaction rules
  logic [7:0] ref_mem [0:255];

  function automatic int bidx(input logic [31:0] a);
    return widx(a) * 4 + int'(a[1:0]);
  endfunction

  function automatic logic reg_ok(input logic [31:0] a, input logic st);
    return st ? (a[31:16] == 16'h1000) : (a[31:16] == 16'h1000 || a[31:16] == 16'h0000);
  endfunction

  task automatic model_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, output logic [1:0] flt,
                           output int unsigned nacc, output logic [31:0] wa0, output logic [31:0] wa1,
                           output logic [3:0] m0, output logic [3:0] m1,
                           output logic [31:0] d0, output logic [31:0] d1, output logic [31:0] ld);
    int unsigned sz;
    int unsigned nw;
    int          lane;
    logic        ill, mis, aerr;
    logic [31:0] last, ba, raw, ext;
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 1;
    endcase
    ill = st ? !(f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd3, 3'd6, 3'd7});
`ifdef LSU_MISALIGNED_SPLIT_EN
    mis = 1'b0;
`else
    mis = (a % sz) != 0;
`endif
    wa0  = a & ~32'd3;
    last = a + 32'(sz) - 32'd1;
    wa1  = last & ~32'd3;
    nw   = (wa1 != wa0) ? 2 : 1;
    aerr = !reg_ok(wa0, st) || (nw == 2 && !reg_ok(wa1, st));
    if (ill)       flt = 2'b11;
    else if (mis)  flt = 2'b01;
    else if (aerr) flt = 2'b10;
    else           flt = 2'b00;
    nacc = (flt == 2'b00) ? nw : 0;
    m0 = '0; m1 = '0; d0 = '0; d1 = '0; raw = '0;
    // Every byte of the store value lands at address a+i; mask covers only the access size.
    for (int i = 0; i < 4; i++) begin
      ba   = a + 32'(i);
      lane = int'(ba[1:0]);
      if ((ba & ~32'd3) == wa0) begin
        d0[lane*8 +: 8] = sd[i*8 +: 8];
        if (i < int'(sz)) m0[lane] = 1'b1;
      end else begin
        d1[lane*8 +: 8] = sd[i*8 +: 8];
        if (i < int'(sz)) m1[lane] = 1'b1;
      end
    end
    if (!st && flt == 2'b00)
      for (int i = 0; i < int'(sz); i++) raw[i*8 +: 8] = ref_mem[bidx(a + 32'(i))];
    case (f3)
      3'd0:    ext = {{24{raw[7]}}, raw[7:0]};
      3'd1:    ext = {{16{raw[15]}}, raw[15:0]};
      3'd4:    ext = {24'd0, raw[7:0]};
      3'd5:    ext = {16'd0, raw[15:0]};
      default: ext = raw;
    endcase
    ld = (!st && flt == 2'b00) ? ext : 32'd0;
    if (st && flt == 2'b00)
      for (int i = 0; i < int'(sz); i++) ref_mem[bidx(a + 32'(i))] = sd[i*8 +: 8];
  endtask

  // ---------------- per-cycle expectation queue and the compare process
  typedef struct packed {
    logic        rdy;
    logic        we;
    logic [31:0] addr;
    logic        chk_w;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic        rv;
    logic [31:0] rdata;
    logic [1:0]  rflt;
  } exp_t;

  exp_t expq[$];

  always @(negedge clk) begin
    exp_t e;
    logic ok;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      n_cmp++;
      ok = (req_ready === e.rdy) && (dmem_write_enable === e.we) && (dmem_address === e.addr) &&
           (rsp_valid === e.rv);
      if (e.chk_w) ok = ok && (dmem_write_mask === e.mask) && (dmem_write_data === e.wdata);
      if (e.rv)    ok = ok && (rsp_load_data === e.rdata) && (rsp_fault === e.rflt);
      if (!ok) begin
        n_bad++;
        $display("FAIL cycle t=%0t: got rdy=%b we=%b addr=%h mask=%b wd=%h rv=%b rd=%h flt=%b ; want rdy=%b we=%b addr=%h mask=%b wd=%h rv=%b rd=%h flt=%b (chk_w=%b)",
                 $time, req_ready, dmem_write_enable, dmem_address, dmem_write_mask, dmem_write_data,
                 rsp_valid, rsp_load_data, rsp_fault, e.rdy, e.we, e.addr, e.mask, e.wdata,
                 e.rv, e.rdata, e.rflt, e.chk_w);
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // ---------------- driver: one transaction, rsp_ready held low for d RESP cycles
  logic [31:0] o_data, o_addr1, o_wd1;
  logic [1:0]  o_flt;
  logic        o_we1;
  logic [3:0]  o_mask1;

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input int unsigned d);
    logic [1:0]  flt;
    int unsigned nacc, guard;
    logic [31:0] wa0, wa1, d0, d1, ld;
    logic [3:0]  m0, m1;
    exp_t        e;
    model_txn(st, f3, a, sd, flt, nacc, wa0, wa1, m0, m1, d0, d1, ld);
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_ready_timeout: got 0 expected 1 after %0d cycles", guard);
      return;
    end
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_address = a; req_store_data = sd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    for (int unsigned k = 0; k < nacc; k++) begin
      e = '0;
      e.we    = st;
      e.addr  = (k == 0) ? wa0 : wa1;
      e.chk_w = st;
      e.mask  = (k == 0) ? m0 : m1;
      e.wdata = (k == 0) ? d0 : d1;
      expq.push_back(e);
    end
    for (int unsigned k = 0; k <= d; k++) begin
      e = '0;
      e.chk_w = 1'b1;
      e.rv    = 1'b1;
      e.rdata = ld;
      e.rflt  = flt;
      expq.push_back(e);
    end
    e = '0;
    e.rdy   = 1'b1;
    e.chk_w = 1'b1;
    expq.push_back(e);
    o_we1 = dmem_write_enable; o_addr1 = dmem_address; o_mask1 = dmem_write_mask; o_wd1 = dmem_write_data;
    repeat (nacc + d) @(posedge clk);
    #1;
    o_data = rsp_load_data;
    o_flt  = rsp_fault;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, w_a, w_b;
    logic [2:0]  f3;
    logic [15:0] region, lo;
    int unsigned r;
    reset_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0;
    req_address = '0; req_store_data = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    lit("reset_req_ready", {31'd0, req_ready}, 32'd1);
    lit("reset_we", {31'd0, dmem_write_enable}, 32'd0);
    lit("reset_addr", dmem_address, 32'd0);
    lit("reset_mask", {28'd0, dmem_write_mask}, 32'd0);
    lit("reset_wdata", dmem_write_data, 32'd0);
    lit("reset_rsp", {rsp_valid, rsp_fault, 29'd0} | rsp_load_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int w = 0; w < 64; w++)
      for (int l = 0; l < 4; l++) ref_mem[w*4 + l] = dmem[w][l*8 +: 8];

    // Directed cases with hand-computed results.
    do_req(1'b1, 3'b010, 32'h10000008, 32'hDEADBEEF, 0);
    lit("sw_acc0_addr", o_addr1, 32'h10000008);
    lit("sw_acc0_mask", {28'd0, o_mask1}, 32'h0000000F);
    lit("sw_acc0_we", {31'd0, o_we1}, 32'd1);
    lit("sw_fault", {30'd0, o_flt}, 32'd0);
    do_req(1'b0, 3'b010, 32'h10000008, 32'h0, 0);
    lit("lw_after_sw", o_data, 32'hDEADBEEF);

    do_req(1'b1, 3'b000, 32'h10000003, 32'h000000A5, 0);
    lit("sb_mask", {28'd0, o_mask1}, 32'h00000008);
    lit("sb_wdata", o_wd1, 32'hA5000000);
    do_req(1'b0, 3'b000, 32'h10000003, 32'h0, 1);
    lit("lb_sign", o_data, 32'hFFFFFFA5);
    do_req(1'b0, 3'b100, 32'h10000003, 32'h0, 0);
    lit("lbu_zero", o_data, 32'h000000A5);

    do_req(1'b1, 3'b010, 32'h10000000, 32'h80010000, 0);
    do_req(1'b0, 3'b001, 32'h10000002, 32'h0, 0);
    lit("lh_sign", o_data, 32'hFFFF8001);
    do_req(1'b0, 3'b101, 32'h10000002, 32'h0, 2);
    lit("lhu_zero", o_data, 32'h00008001);

    do_req(1'b1, 3'b010, 32'h00000010, 32'h12345678, 0);
    lit("sw_rom_fault", {30'd0, o_flt}, 32'd2);
    lit("sw_rom_no_we", {31'd0, o_we1}, 32'd0);
    do_req(1'b0, 3'b010, 32'h20000000, 32'h0, 0);
    lit("lw_bad_fault", {30'd0, o_flt}, 32'd2);
    lit("lw_bad_data", o_data, 32'd0);
    do_req(1'b0, 3'b011, 32'h10000000, 32'h0, 0);
    lit("ld_illegal", {30'd0, o_flt}, 32'd3);

    do_req(1'b1, 3'b010, 32'h10000004, 32'h44332211, 0);
    do_req(1'b1, 3'b010, 32'h10000008, 32'h88776655, 0);
    do_req(1'b0, 3'b010, 32'h10000006, 32'h0, 3);
`ifdef LSU_MISALIGNED_SPLIT_EN
    lit("lw_split_data", o_data, 32'h66554433);
    lit("lw_split_fault", {30'd0, o_flt}, 32'd0);
    do_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 0);
    lit("lw_wrap_fault", {30'd0, o_flt}, 32'd2);
    do_req(1'b0, 3'b001, 32'h10000005, 32'h0, 0);
    lit("lh_off1_single", {30'd0, o_flt}, 32'd0);
`else
    lit("lw_misaligned", {30'd0, o_flt}, 32'd1);
    lit("lw_misaligned_data", o_data, 32'd0);
    do_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 0);
    lit("lw_wrap_fault", {30'd0, o_flt}, 32'd1);
    do_req(1'b0, 3'b001, 32'h10000005, 32'h0, 0);
    lit("lh_off1_misaligned", {30'd0, o_flt}, 32'd1);
`endif

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      region = (r < 60) ? 16'h1000 : (r < 85) ? 16'h0000 : (r < 93) ? 16'h2000 : 16'hFFFF;
      lo = ($urandom_range(0, 9) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom_range(0, 127));
      a = {region, lo};
      case ($urandom_range(0, 6))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        4: f3 = 3'b101;
        5: f3 = 3'b010;
        default: f3 = 3'($urandom_range(0, 7));
      endcase
      do_req(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom_range(0, 3));
    end

    // Reset during ACC0 of a store: nothing may be written.
`ifdef LSU_MISALIGNED_SPLIT_EN
    a = 32'h10000016;
`else
    a = 32'h10000014;
`endif
    @(negedge clk);
    w_a = dmem[widx(32'h10000014)];
    w_b = dmem[widx(32'h10000018)];
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010; req_address = a;
    req_store_data = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lit("rst_acc0_we", {31'd0, dmem_write_enable}, 32'd1);
    lit("rst_acc0_addr", dmem_address, 32'h10000014);
    #2;
    reset_n = 1'b0;
    #1;
    lit("rst_mid_we", {31'd0, dmem_write_enable}, 32'd0);
    lit("rst_mid_addr", dmem_address, 32'd0);
    lit("rst_mid_mask_wd", {28'd0, dmem_write_mask} | dmem_write_data, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    lit("rst_rel_ready", {31'd0, req_ready}, 32'd1);
    lit("rst_rel_rsp", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    lit("rst_no_acc1_we", {31'd0, dmem_write_enable}, 32'd0);
    lit("rst_no_acc1_addr", dmem_address, 32'd0);
    lit("rst_word0_kept", dmem[widx(32'h10000014)], w_a);
    lit("rst_word1_kept", dmem[widx(32'h10000018)], w_b);

    // Unit must work normally afterwards.
    do_req(1'b1, 3'b001, 32'h10000020, 32'h0000BEEF, 0);
    do_req(1'b0, 3'b101, 32'h10000020, 32'h0, 1);
    lit("post_reset_lhu", o_data, 32'h0000BEEF);

    @(negedge clk);
    #1;
    lit("queue_drained", expq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface. Accepts one load/store request at a time from the execute stage.
- Generates word-aligned address, byte-lane write data and 4-bit write mask for the data memory. The data memory has a combinational read and a posedge write.
- Extracts and extends load data, and reports misaligned and access faults.
- Sits between the core pipeline and the data memory / ROM read path.

Parameters:
- RAM_REGION, 16'h1000, address[31:16] value of writable RAM.
- ROM_REGION, 16'h0000, address[31:16] value of read-only ROM.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_address  in  32  byte address.
- req_store_data  in  32  store value, right-justified.
- dmem_write_enable  out  1  write strobe to data memory.
- dmem_address  out  32  word-aligned address, bits [1:0] = 0.
- dmem_write_data  out  32  lane-shifted store data.
- dmem_write_mask  out  4  byte-lane enables.
- dmem_read_data  in  32  combinational read word.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_load_data  out  32  extended load result; 0 for stores and faults.
- rsp_fault  out  2  00 none, 01 misaligned, 10 access, 11 illegal funct3.

Behaviour:
- Reset (any time, including mid-access): state IDLE; all dmem_* outputs 0; rsp_valid, rsp_load_data and rsp_fault 0; captured request discarded. A second split half is never issued after reset.
- States:
  - IDLE: req_ready = 1. On req_valid, latch the request and classify it.
    - If it faults, go to RESP with no memory access.
    - Otherwise go to ACC0.
  - ACC0: drive the first word. For a load, capture dmem_read_data at the clock edge. If the access is split, go to ACC1; otherwise go to RESP.
  - ACC1: drive word address + 4 (wraps 0xFFFFFFFC -> 0x00000000). Capture the second word, then go to RESP.
  - RESP: rsp_valid = 1, held stable until rsp_ready. On handshake go to IDLE; no same-cycle new-request acceptance.
- dmem_* outputs are nonzero only in ACC0/ACC1. dmem_write_enable = is_store, and is high for exactly one cycle per state.
- Lane rules:
  - off = address[1:0].
  - mask = (B: 0001, H: 0011, W: 1111) << off, truncated to 4 bits in ACC0. The overflow bits form the ACC1 mask.
  - write_data = store_data << 8*off in ACC0, and store_data >> 8*(4-off) in ACC1.
- Load extraction: form {word1, word0} >> 8*off, select the low 8/16/32 bits, then sign-extend (B, H) or zero-extend (BU, HU).
- Illegal funct3 takes priority: for loads, 011, 110 and 111; for stores, anything other than 000/001/010.
- Access fault:
  - For a store, any touched word's address[31:16] != RAM_REGION.
  - For a load, any touched word's region is neither RAM_REGION nor ROM_REGION.
- Fault priority: illegal > misaligned > access.
- Latency: accept at cycle 0, ACC0 at cycle 1, rsp_valid at cycle 2. Split accesses give rsp_valid at cycle 3. Fault responses give rsp_valid at cycle 1.

Optional Feature:
- Macro: LSU_MISALIGNED_SPLIT_EN.
- Defined: accesses with H and off = 1 stay a single access. H with off = 3, and W with off != 0, are split into ACC0 + ACC1. For a store, the ACC1 write happens only if both halves pass the access check; nothing is written on fault.
- Undefined: H with address[0] = 1, or W with off != 0, returns rsp_fault 01 with no memory access. ACC1 logic is removed.

Decomposition:
- Package lsu_pkg: funct3 constants, fault code constants, state enum (IDLE/ACC0/ACC1/RESP).
- Sub-module lsu_load_align: combinational extraction and extension from {word1, word0}, off and funct3.

Test Plan:
- SW 0xDEADBEEF to 0x10000008 -> ACC0 at cycle 1: addr 0x10000008, mask 1111, we = 1. rsp_valid at cycle 2 with fault 00; a following LW returns 0xDEADBEEF.
- SB 0x000000A5 to 0x10000003 -> mask 1000, write_data 0xA5000000. A following LB returns 0xFFFFFFA5, and LBU returns 0x000000A5.
- LH at 0x10000002 over word 0x80010000 -> 0xFFFF8001. LHU -> 0x00008001.
- SW to 0x00000010 (ROM) -> rsp_fault 10, no write pulse. LW at 0x20000000 -> fault 10, rsp_load_data 0.
- LW at 0x10000006 with words 0x44332211 at 0x10000004 and 0x88776655 at 0x10000008:
  - With macro: two access cycles, result 0x66554433.
  - Without macro: fault 01 at cycle 1.
- Hold rsp_ready = 0 for 3 cycles -> rsp stays stable. Assert reset_n = 0 during ACC0 of a split store -> no ACC1 write; all outputs 0 and req_ready = 1 after release.
